pe_weight_loader: RTL
=====================

# pe_weight_loader

Streams a column of signed weights into a chain of N weight-stationary PEs, where each PE's weight output feeds the next PE's weight input. The loader accepts N weights over a valid/ready handshake and buffers them. It then drives the chain's shared weight input and load strobe for N shift cycles, so weight k ends up in PE k. It sits between the weight fetch path and the head (PE 0) of each PE column, and reports when the column holds a complete, valid weight set.

## Interface
- W, 8, weight width in bits (signed two's complement).
- N, 4, number of PEs in the chain; N ≥ 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  upstream weight valid.
- s_ready  out  1  loader can accept a weight this cycle.
- s_data  in  W  signed weight; word i accepted (i = 0..N-1) is destined for PE i.
- hold  in  1  array controller stall; pauses shifting while high.
- pe_a  out  W  weight driven into PE 0 of the chain.
- pe_load  out  1  load strobe to every PE in the chain (all shift together).
- done  out  1  one-cycle pulse when the column has been fully loaded.
- weights_valid  out  1  level; the chain holds a complete weight set.

## Operation
- States: IDLE, FILL, SHIFT, DONE. Registers: buf[0..N-1] (W each), cnt (accepted count), idx (shift index), weights_valid.
- Accept: a word is taken when s_valid && s_ready. It is written to buf[cnt], and cnt increments.
- s_ready = 1 in IDLE and FILL; s_ready = 0 in SHIFT and DONE.
- IDLE → FILL on the first accept, or → SHIFT directly when N words have been accepted. No accept keeps the block in IDLE.
- FILL → SHIFT on the cycle the Nth word is accepted. cnt clears to 0 and idx loads N-1.
- SHIFT:
  - pe_load = !hold.
  - pe_a = buf[idx].
  - Each cycle with pe_load = 1, idx decrements.
  - When pe_load = 1 and idx = 0, go → DONE.
  - While hold = 1, idx and pe_a are frozen.
- Shift order: the chain shifts PE i-1 → PE i on each strobe. Driving buf[N-1] first and buf[0] last leaves buf[k] in PE k after exactly N strobes.
- DONE: done = 1 and weights_valid is set to 1, both in this cycle. Then → IDLE unconditionally.
- weights_valid:
  - Clears to 0 on the first SHIFT cycle with pe_load = 1, because the chain is then partially overwritten.
  - Stays 1 through IDLE and FILL of a reload.
- Outside SHIFT: pe_load = 0 and pe_a = 0.
- Data passes through unmodified; there is no arithmetic, and the sign is preserved bit-exact.

## Timing
- Reset (rst sampled high):
  - Next state is IDLE.
  - cnt = 0, idx = 0, buf all 0, weights_valid = 0.
  - Outputs: s_ready = 1, pe_load = 0, pe_a = 0, done = 0.
- Reset mid-operation (FILL or SHIFT) abandons the load. The chain contents are undefined and weights_valid = 0 until a full reload completes.
- s_ready, pe_load and pe_a are combinational decodes of registered state plus hold. There is no combinational path from s_valid to s_ready.
- Nth accept at edge t gives:
  - pe_load high in cycles t+1 .. t+N when hold = 0.
  - done and weights_valid = 1 in cycle t+N+1.
  - s_ready = 1 again in cycle t+N+2.
- Each held cycle extends the shift window by one cycle. The pe_load pulse count is always exactly N.
- Minimum period per column load is 2N+1 cycles: N fill, N shift, 1 done.
- s_valid asserted during SHIFT or DONE is ignored. The source must hold the word until s_ready = 1.
- hold has no effect outside SHIFT.

## Test plan
- N=4, back-to-back words 10, -20, 30, -40:
  - s_ready falls after the 4th accept.
  - pe_load is high for 4 cycles with pe_a = -40, 30, -20, 10.
  - A 4-PE shift model ends at PE0..3 = 10, -20, 30, -40.
  - done pulses once, and weights_valid = 1.
- Same words with s_valid gaps of 1–3 cycles: identical PE contents. Only handshaked words are counted.
- hold high for 3 cycles starting at the 2nd shift cycle:
  - pe_load = 0 and pe_a frozen at 30 during the hold.
  - Exactly 4 strobes total; done arrives 3 cycles late.
- s_valid held high with data 99 through SHIFT/DONE: not accepted until s_ready returns; 99 is then stored as word 0 of the next load.
- rst asserted after 2 shift strobes:
  - Next cycle is IDLE, with pe_load = 0, done = 0 and weights_valid = 0.
  - A subsequent full load of 1, 2, 3, 4 yields PE0..3 = 1, 2, 3, 4.
- Reload while weights_valid = 1 (words 5, 6, 7, 8): weights_valid stays 1 during FILL, drops on the first strobe, and returns to 1 with done.

Source files
------------

// File: rtl/pe_weight_loader_if.sv
// rtl/pe_weight_loader_if.sv - weight stream and PE-chain drive bundle for pe_weight_loader
interface pe_weight_loader_if #(
    parameter int W = 8
);
    logic                s_valid;
    logic                s_ready;
    logic signed [W-1:0] s_data;
    logic                hold;
    logic signed [W-1:0] pe_a;
    logic                pe_load;
    logic                done;
    logic                weights_valid;

    modport master (
        output s_valid, s_data, hold,
        input  s_ready, pe_a, pe_load, done, weights_valid
    );

    modport slave (
        input  s_valid, s_data, hold,
        output s_ready, pe_a, pe_load, done, weights_valid
    );
endinterface

// File: rtl/pe_weight_loader.sv
// rtl/pe_weight_loader.sv - buffers N weights, then shifts them into a weight-stationary PE chain
module pe_weight_loader #(
    parameter int W = 8,
    parameter int N = 4
) (
    input logic              clk,
    input logic              rst,
    pe_weight_loader_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, FILL, SHIFT, DONE} state_t;

    state_t              state, state_nxt;
    logic signed [W-1:0] wbuf [N];
    logic [IW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic                wv;

    logic                accept;
    logic                s_ready;
    logic                pe_load;
    logic signed [W-1:0] pe_a;
    logic                done;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        s_ready   = 1'b0;
        pe_load   = 1'b0;
        pe_a      = '0;
        done      = 1'b0;
        case (state)
            IDLE, FILL: begin
                s_ready = 1'b1;
                accept  = bus.s_valid;
                if (accept)
                    state_nxt = (cnt == LAST) ? SHIFT : FILL;
            end
            SHIFT: begin
                // Last buffered word goes out first so word k settles in PE k.
                pe_load = !bus.hold;
                pe_a    = wbuf[idx];
                if (pe_load && idx == '0)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            wv    <= 1'b0;
            for (int i = 0; i < N; i++)
                wbuf[i] <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wbuf[cnt] <= bus.s_data;
                if (cnt == LAST) begin
                    cnt <= '0;
                    idx <= LAST;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            // The first strobe starts overwriting the chain, so the old set is gone.
            if (pe_load) begin
                wv <= 1'b0;
                if (idx != '0)
                    idx <= idx - 1'b1;
            end
            if (done)
                wv <= 1'b1;
        end
    end

    assign bus.s_ready       = s_ready;
    assign bus.pe_load       = pe_load;
    assign bus.pe_a          = pe_a;
    assign bus.done          = done;
    assign bus.weights_valid = wv | done;
endmodule
